// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with an APB register interface and a small receive FIFO.
// Registers: DATA (0x0, read pops), STATUS (0x4, W1C error flags), CTRL (0x8).
module uart_rx_ctrl #(
   parameter int DIVISOR    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [3:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       rx_irq
);

   localparam int BW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [BW-1:0] BAUD_HALF = BW'(DIVISOR / 2 - 1);
   localparam logic [BW-1:0] BAUD_FULL = BW'(DIVISOR - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            rx_s1_q, rx_s2_q;
   logic            en_q, en_d, irq_en_q, irq_en_d;
   logic            overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic rxs;
   logic access, wr_status, wr_ctrl, rd_data;
   logic full, empty, pop, push_req, push_ok, overrun_set, frame_set;
   logic unused_pwdata;

   assign rxs           = rx_s2_q;
   assign unused_pwdata = ^pwdata[7:4];

   assign access    = psel & penable;
   assign wr_status = access & pwrite & (paddr == 4'h4);
   assign wr_ctrl   = access & pwrite & (paddr == 4'h8);
   assign rd_data   = access & ~pwrite & (paddr == 4'h0);

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = rd_data & ~empty;

   // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
   assign push_ok     = push_req & (~full | pop);
   assign overrun_set = push_req & full & ~pop;

   assign pready = 1'b1;
   assign rx_irq = ~empty & irq_en_q;

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push_req  = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_q && !rxs) begin
               state_d = START;
               baud_d  = BAUD_HALF;
            end
         end
         START: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else begin
               baud_d  = BAUD_FULL;
               bit_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else begin
               shift_d = {rxs, shift_q[7:1]};
               baud_d  = BAUD_FULL;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_q != '0) begin
               baud_d = baud_q - 1'b1;
            end else begin
               push_req  = rxs;
               frame_set = ~rxs;
               baud_d    = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Disabling mid-frame abandons the partial byte without touching flags.
      if (state_q != IDLE && !en_q) begin
         state_d   = IDLE;
         baud_d    = '0;
         bit_d     = '0;
         push_req  = 1'b0;
         frame_set = 1'b0;
      end
   end

   always_comb begin
      en_d        = en_q;
      irq_en_d    = irq_en_q;
      if (wr_ctrl) begin
         en_d     = pwdata[0];
         irq_en_d = pwdata[1];
      end
      overrun_d   = overrun_set | (overrun_q & ~(wr_status & pwdata[3]));
      frame_err_d = frame_set | (frame_err_q & ~(wr_status & pwdata[2]));
      wr_d        = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d        = pop ? rd_q + 1'b1 : rd_q;
   end

   always_comb begin
      prdata = '0;
      if (access && !pwrite) begin
         case (paddr)
            4'h0:    prdata = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
            4'h4:    prdata = {4'b0, overrun_q, frame_err_q, full, ~empty};
            4'h8:    prdata = {6'b0, irq_en_q, en_q};
            default: prdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         en_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
      end else begin
         rx_s1_q     <= rx;
         rx_s2_q     <= rx_s1_q;
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         en_q        <= en_d;
         irq_en_q    <= irq_en_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem_q[wr_q[AW-1:0]] <= shift_q;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: framing, glitch rejection, FIFO full/overrun and APB registers.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [3:0] paddr = '0;
   logic [7:0] pwdata = '0;
   logic [7:0] prdata;
   logic       pready, rx_irq;

   int n_pass = 0;
   int n_total = 0;
   logic [7:0] rd;

   uart_rx_ctrl #(.DIVISOR(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .rx_irq(rx_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apb_write(input logic [3:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [7:0] d);
      @(posedge clk); #1;
      psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      #2 d = prdata;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // One 8N1 frame, 8 clocks per bit; returns 1 ns after the clock edge ending the stop bit.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (8) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      idle(1);

      // Reset state
      check("rst_pready", {7'b0, pready}, 8'h01);
      check("rst_irq", {7'b0, rx_irq}, 8'h00);
      apb_read(4'h4, rd); check("rst_status", rd, 8'h00);
      apb_read(4'h8, rd); check("rst_ctrl", rd, 8'h00);
      apb_read(4'h0, rd); check("rst_data_empty", rd, 8'h00);
      apb_read(4'hC, rd); check("unmapped_read", rd, 8'h00);

      // Single byte 0xA5
      apb_write(4'h8, 8'h03);
      apb_read(4'h8, rd); check("ctrl_rw", rd, 8'h03);
      send_byte(8'hA5, 1'b1);
      idle(2);
      check("a5_irq", {7'b0, rx_irq}, 8'h01);
      apb_read(4'h4, rd); check("a5_status", rd, 8'h01);
      apb_write(4'h0, 8'hFF);
      apb_read(4'h0, rd); check("a5_data", rd, 8'hA5);
      apb_read(4'h4, rd); check("a5_status_after", rd, 8'h00);
      check("a5_irq_after", {7'b0, rx_irq}, 8'h00);

      // Two-clock glitch on the idle line
      rx = 1'b0; idle(2); rx = 1'b1;
      idle(20);
      apb_read(4'h4, rd); check("glitch_status", rd, 8'h00);

      // Frame error
      send_byte(8'h3C, 1'b0);
      idle(20);
      apb_read(4'h4, rd); check("ferr_status", rd, 8'h04);
      apb_write(4'h4, 8'h00);
      apb_read(4'h4, rd); check("ferr_w0_keeps", rd, 8'h04);
      apb_write(4'h4, 8'h04);
      apb_read(4'h4, rd); check("ferr_cleared", rd, 8'h00);

      // Overrun: five bytes into a four-deep FIFO
      for (int i = 1; i <= 5; i++) begin
         send_byte(8'(i), 1'b1);
         idle(2);
      end
      apb_read(4'h4, rd); check("ovr_status", rd, 8'h0B);
      for (int i = 1; i <= 4; i++) begin
         apb_read(4'h0, rd); check("ovr_data", rd, 8'(i));
      end
      apb_read(4'h0, rd); check("ovr_data_empty", rd, 8'h00);
      apb_read(4'h4, rd); check("ovr_status_drained", rd, 8'h08);
      apb_write(4'h4, 8'h08);
      apb_read(4'h4, rd); check("ovr_cleared", rd, 8'h00);

      // Full FIFO, pop coincides with push of 0x15
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h11 + 8'(i), 1'b1);
         idle(2);
      end
      apb_read(4'h4, rd); check("full_status", rd, 8'h03);
      fork
         send_byte(8'h15, 1'b1);
         begin
            repeat (77) @(posedge clk);
            #1 psel = 1'b1; pwrite = 1'b0; paddr = 4'h0;
            @(posedge clk);
            #1 penable = 1'b1;
            #2 rd = prdata;
            @(posedge clk);
            #1 psel = 1'b0; penable = 1'b0;
         end
      join
      check("coinc_read", rd, 8'h11);
      idle(2);
      apb_read(4'h4, rd); check("coinc_status", rd, 8'h03);
      for (int i = 0; i < 4; i++) begin
         apb_read(4'h0, rd); check("coinc_data", rd, 8'h12 + 8'(i));
      end
      apb_read(4'h4, rd); check("coinc_status_end", rd, 8'h00);

      // Disable mid-frame, then a clean frame
      fork
         send_byte(8'h77, 1'b1);
         begin
            repeat (45) @(posedge clk);
            apb_write(4'h8, 8'h02);
         end
      join
      idle(4);
      apb_read(4'h4, rd); check("dis_status", rd, 8'h00);
      apb_write(4'h8, 8'h03);
      send_byte(8'h5A, 1'b1);
      idle(2);
      apb_read(4'h0, rd); check("dis_next_data", rd, 8'h5A);
      apb_read(4'h4, rd); check("dis_next_status", rd, 8'h00);

      // Reset mid-frame
      fork
         send_byte(8'h99, 1'b1);
         begin
            repeat (40) @(posedge clk);
            #1 rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      idle(4);
      apb_read(4'h4, rd); check("rstmid_status", rd, 8'h00);
      apb_read(4'h8, rd); check("rstmid_ctrl", rd, 8'h00);
      check("rstmid_irq", {7'b0, rx_irq}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
